// File: rtl/mux_n_skid.sv
// N:1 operand selector with a registered output and a 2-entry skid buffer.
// Out-of-range selects yield zero and bump a saturating error counter.
module mux_n_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ERR_W-1:0]   err_count,
  input  logic               err_clr
);

  // Encoding is {main_v, skid_v} so both valid bits come straight from flops.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [WIDTH-1:0]   mux_data;
  logic               sel_oor;
  logic               accept;
  logic               pop;

  // A select matching no input index is out of range (sel >= N).
  always_comb begin
    mux_data = '0;
    sel_oor  = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_data = data_in[i*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign err_count = err_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_data_d = mux_data;
          main_sel_d  = sel;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_data_d = mux_data;
          main_sel_d  = sel;
        end else if (accept) begin
          skid_data_d = mux_data;
          skid_sel_d  = sel;
          state_d     = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (accept && sel_oor && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_n_skid.sv
// Scoreboard bench for mux_n_skid (N=5, SEL_W=3, WIDTH=8, ERR_W=2): directed
// select/backpressure/saturation/reject/reset scenarios, then random traffic.
module tb_mux_n_skid;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned N       = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ERR_W   = 2;
  localparam int          ERR_MAX = 3;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;
  logic [ERR_W-1:0]   err_count;
  logic               err_clr;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   acc_now = 1'b0;
  int   err_exp = 0;
  int   err_next = 0;

  mux_n_skid #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_sel(input logic [N*WIDTH-1:0] d,
                                               input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] words [N];
    for (int i = 0; i < int'(N); i++) words[i] = d[i*WIDTH +: WIDTH];
    if (int'(s) < int'(N)) return words[int'(s)];
    return '0;
  endfunction

  function automatic logic [N*WIDTH-1:0] rand_data();
    logic [N*WIDTH-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom());
    return v;
  endfunction

  // One cycle of stimulus; the expected output is queued when the offer is accepted.
  task automatic drive(input logic iv, input logic [SEL_W-1:0] s, input logic [N*WIDTH-1:0] d,
                       input logic ordy, input logic clr, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    err_exp   = err_next;
    in_valid  = iv;
    sel       = s;
    data_in   = d;
    out_ready = ordy;
    err_clr   = clr;
    acc       = iv && (q.size() < 2);
    acc_now   = acc;
    if (acc) begin
      e.d = ref_sel(d, s);
      e.s = s;
      q.push_back(e);
    end
    if (clr) err_next = 0;
    else if (acc && int'(s) >= int'(N) && err_exp < ERR_MAX) err_next = err_exp + 1;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    drive(1'b0, '0, rand_data(), ordy, 1'b0, a);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
  endtask

  // Monitor: compares the visible output stage against the oldest queued entry.
  always @(negedge clk) begin
    int occ;
    if (rst_n) begin
      occ = q.size() - (acc_now ? 1 : 0);
      check("out_valid", 32'(out_valid), 32'(occ > 0));
      check("in_ready", 32'(in_ready), 32'(occ < 2));
      check("err_count", 32'(err_count), 32'(err_exp));
      if (occ > 0) begin
        check("out_data", 32'(out_data), 32'(q[0].d));
        check("out_sel", 32'(out_sel), 32'(q[0].s));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic               a;
    logic [N*WIDTH-1:0] dv;
    int                 k;
    rst_n     = 1'b0;
    data_in   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #3;
    check_reset_state();
    #9 rst_n = 1'b1;

    // Select sweep including every out-of-range code.
    dv = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 8; i++) drive(1'b1, SEL_W'(i), dv, 1'b1, 1'b0, a);
    idle(1'b1);
    check("sweep_err_count", 32'(err_count), 32'd3);
    drive(1'b0, '0, dv, 1'b1, 1'b1, a);
    idle(1'b1);
    check("clr_err_count", 32'(err_count), 32'd0);

    // Saturation, then clear coinciding with a bad accept.
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd7, rand_data(), 1'b1, 1'b0, a);
    drive(1'b1, 3'd6, rand_data(), 1'b1, 1'b1, a);
    idle(1'b1);
    check("sat_clr_err_count", 32'(err_count), 32'd0);

    // Backpressure: stream 1..4 with out_ready low from cycle 1 to 5.
    k = 1;
    for (int c = 0; c < 30 && k <= 4; c++) begin
      dv = rand_data();
      dv[WIDTH-1:0] = WIDTH'(k);
      drive(1'b1, '0, dv, (c >= 1 && c <= 5) ? 1'b0 : 1'b1, 1'b0, a);
      if (a) k++;
    end
    check("bp_all_accepted", 32'(k), 32'd5);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Fill to FULL, then offer bad selects that must be rejected.
    drive(1'b1, 3'd1, rand_data(), 1'b0, 1'b0, a);
    drive(1'b1, 3'd2, rand_data(), 1'b0, 1'b0, a);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd7, rand_data(), 1'b0, 1'b0, a);
    idle(1'b0);
    check("reject_err_count", 32'(err_count), 32'd0);
    check("reject_in_ready", 32'(in_ready), 32'd0);

    // Asynchronous reset while FULL, asserted between edges.
    #2 rst_n = 1'b0;
    #1;
    check_reset_state();
    q.delete();
    acc_now  = 1'b0;
    err_exp  = 0;
    err_next = 0;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    dv = '0;
    dv[WIDTH-1:0] = 8'hA5;
    drive(1'b1, '0, dv, 1'b1, 1'b0, a);
    idle(1'b1);
    check("post_rst_data", 32'(out_data), 32'hA5);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    check("post_rst_single", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, 7)), rand_data(),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0), a);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
